// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the program counter and feeds the decode stage. Requests instruction
// words from memory with a req/ack handshake, holds one fetched word in an
// output register with a valid/ready handshake, and discards responses that
// a redirect has made stale. Without a redirect the PC steps by STEP bytes.
//
// Optional feature (compile-time macro FETCH_PERF_CNT_EN):
//   defined   -> fetch_count port present, counts delivered instructions
//   undefined -> no counter, no port
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous, active-high reset
//   redirect_valid in   one-cycle pulse: load PC from redirect_addr
//   redirect_addr  in   new PC (bit 0 forced to 0)
//   imem_req       out  read request to instruction memory
//   imem_addr      out  read address, stable while the request is pending
//   imem_ack       in   one-cycle response strobe, imem_rdata valid with it
//   imem_rdata     in   fetched instruction
//   instr_valid    out  instruction available to decode
//   instr_data     out  held instruction
//   instr_pc       out  address instr_data was fetched from
//   instr_ready    in   decode accepts when instr_valid is high
//   fetch_count    out  delivered-instruction count (FETCH_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INSTR_W  = 20,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       STEP     = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_data,
   output logic [ADDR_W-1:0]  instr_pc,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]        fetch_count,
`endif
   input  logic               instr_ready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2,
      S_HOLD = 2'd3
   } state_e;

   state_e             state_q;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  drop_addr_q;   // address of the request being drained in S_DROP
   logic               instr_valid_q;
   logic [INSTR_W-1:0] instr_data_q;
   logic [ADDR_W-1:0]  instr_pc_q;
   logic [ADDR_W-1:0]  redirect_tgt;

   // Instructions are halfword aligned; the adder's bit 0 is meaningless.
   assign redirect_tgt = {redirect_addr[ADDR_W-1:1], 1'b0};

   // Next PC. A redirect wins in every state, including over the +STEP of a
   // same-cycle transfer. The sum wraps naturally at ADDR_W bits.
   always_comb begin
      // NOTE: default first, so every path assigns pc_d and no latch is inferred.
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_tgt;
      end else if (state_q == S_HOLD && instr_ready) begin
         pc_d = pc_q + ADDR_W'(STEP);
      end
   end

   // Fetch FSM and output buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         drop_addr_q   <= RESET_PC;
         instr_valid_q <= 1'b0;
         instr_data_q  <= '0;
         instr_pc_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // samples the pre-edge values of the others.
         pc_q <= pc_d;
         unique case (state_q)
            S_IDLE: begin
               state_q <= S_REQ;
            end
            S_REQ: begin
               if (imem_ack) begin
                  // Ack with a same-cycle redirect: the word is stale, refetch
                  // at the new pc (already loaded through pc_d).
                  if (!redirect_valid) begin
                     instr_data_q  <= imem_rdata;
                     instr_pc_q    <= pc_q;
                     instr_valid_q <= 1'b1;
                     state_q       <= S_HOLD;
                  end
               end else if (redirect_valid) begin
                  // Memory still owes a response for the old address; keep
                  // presenting it until the ack drains it.
                  drop_addr_q <= pc_q;
                  state_q     <= S_DROP;
               end
            end
            S_DROP: begin
               if (imem_ack) begin
                  state_q <= S_REQ;
               end
            end
            S_HOLD: begin
               // instr_valid is always high here, so ready alone is a transfer.
               if (redirect_valid || instr_ready) begin
                  instr_valid_q <= 1'b0;
                  state_q       <= S_REQ;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Request outputs decode directly from registered state, so they are glitch
   // free and change only on the clock edge.
   assign imem_req    = (state_q == S_REQ) || (state_q == S_DROP);
   assign imem_addr   = (state_q == S_DROP) ? drop_addr_q : pc_q;
   assign instr_valid = instr_valid_q;
   assign instr_data  = instr_data_q;
   assign instr_pc    = instr_pc_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q, fetch_count_d;

   always_comb begin
      fetch_count_d = fetch_count_q;
      if (instr_valid_q && instr_ready) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count_q <= '0;
      end else begin
         fetch_count_q <= fetch_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. The stimulus thread drives one cycle at
// a time and pushes the expected request addresses and delivered instructions
// into queues; a monitor on the falling edge pops and compares whenever the
// DUT completes a memory handshake or a decode transfer. A second instance
// with RESET_PC = 0xFFFF_FFFE covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned INSTR_W = 20;

   typedef struct {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] data;
   } instr_exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic               rst;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_addr;
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr_data;
   logic [ADDR_W-1:0]  instr_pc;
   logic               instr_ready;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]        fetch_count;
`endif

   // wrap-around instance
   logic               w_rst;
   logic               w_redirect_valid;
   logic [ADDR_W-1:0]  w_redirect_addr;
   logic               w_req;
   logic [ADDR_W-1:0]  w_addr;
   logic               w_ack;
   logic [INSTR_W-1:0] w_rdata;
   logic               w_valid;
   logic [INSTR_W-1:0] w_data;
   logic [ADDR_W-1:0]  w_pc;
   logic               w_ready;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]        w_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [ADDR_W-1:0] addr_q[$];
   instr_exp_t        instr_q[$];

   fetch_sequencer #(
      .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(32'h0000_0000), .STEP(2)
   ) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
`ifdef FETCH_PERF_CNT_EN
      .fetch_count(fetch_count),
`endif
      .instr_ready(instr_ready)
   );

   fetch_sequencer #(
      .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(32'hFFFF_FFFE), .STEP(2)
   ) dut_wrap (
      .clk(clk), .rst(w_rst),
      .redirect_valid(w_redirect_valid), .redirect_addr(w_redirect_addr),
      .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(w_ack), .imem_rdata(w_rdata),
      .instr_valid(w_valid), .instr_data(w_data), .instr_pc(w_pc),
`ifdef FETCH_PERF_CNT_EN
      .fetch_count(w_count),
`endif
      .instr_ready(w_ready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of main-instance inputs, then step past the next edge.
   task automatic cyc(input logic rst_v, input logic redir_v, input logic [ADDR_W-1:0] redir_a,
                      input logic ack_v, input logic [INSTR_W-1:0] rdata_v, input logic ready_v);
      rst            = rst_v;
      redirect_valid = redir_v;
      redirect_addr  = redir_a;
      imem_ack       = ack_v;
      imem_rdata     = rdata_v;
      instr_ready    = ready_v;
      @(posedge clk);
      #1;
   endtask

   // Zero-wait fetch that is accepted by decode on the first valid cycle.
   task automatic fetch_deliver(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
      instr_exp_t e;
      e.pc   = a;
      e.data = d;
      addr_q.push_back(a);
      instr_q.push_back(e);
      cyc(1'b0, 1'b0, '0, 1'b1, d, 1'b1);
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
   endtask

   // Scoreboard monitor, sampling mid-cycle.
   always @(negedge clk) begin
      if (imem_req && imem_ack) begin
         if (addr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_unexpected: ack at addr 0x%0h, no request expected", imem_addr);
         end else begin
            check("imem_addr@ack", 64'(imem_addr), 64'(addr_q.pop_front()));
         end
      end
      if (instr_valid && instr_ready) begin
         if (instr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL instr_unexpected: delivered pc 0x%0h data 0x%0h, none expected",
                     instr_pc, instr_data);
         end else begin
            instr_exp_t e;
            e = instr_q.pop_front();
            check("instr_pc", 64'(instr_pc), 64'(e.pc));
            check("instr_data", 64'(instr_data), 64'(e.data));
         end
      end
   end

   initial begin
      instr_exp_t e;
      rst = 1'b1; redirect_valid = 1'b0; redirect_addr = '0;
      imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      w_rst = 1'b1; w_redirect_valid = 1'b0; w_redirect_addr = '0;
      w_ack = 1'b0; w_rdata = '0; w_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;

      // reset state
      check("rst_imem_req", 64'(imem_req), 64'd0);
      check("rst_imem_addr", 64'(imem_addr), 64'h0);
      check("rst_instr_valid", 64'(instr_valid), 64'd0);
      check("rst_instr_data", 64'(instr_data), 64'h0);
      check("rst_instr_pc", 64'(instr_pc), 64'h0);
`ifdef FETCH_PERF_CNT_EN
      check("rst_fetch_count", 64'(fetch_count), 64'd0);
`endif

      // one cycle in S_IDLE, then the first request
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      check("first_req", 64'(imem_req), 64'd1);
      check("first_addr", 64'(imem_addr), 64'h0);

      // sequential zero-wait fetch
      fetch_deliver(32'h0, 20'h11111);
      fetch_deliver(32'h2, 20'h22222);
      fetch_deliver(32'h4, 20'h33333);
      fetch_deliver(32'h6, 20'h44444);

      // backpressure: 5 cycles of ready=0, with a stray ack that must be ignored
      addr_q.push_back(32'h8);
      e.pc = 32'h8; e.data = 20'h55555;
      instr_q.push_back(e);
      cyc(1'b0, 1'b0, '0, 1'b1, 20'h55555, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, '0, (i == 2), 20'hBAD00, 1'b0);
         check("bp_valid", 64'(instr_valid), 64'd1);
         check("bp_data", 64'(instr_data), 64'h55555);
         check("bp_pc", 64'(instr_pc), 64'h8);
         check("bp_no_req", 64'(imem_req), 64'd0);
         check("bp_pc_held", 64'(imem_addr), 64'h8);
      end
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      check("bp_next_req", 64'(imem_req), 64'd1);
      check("bp_next_addr", 64'(imem_addr), 64'hA);
      check("bp_valid_clr", 64'(instr_valid), 64'd0);

      // redirect while a slow request is outstanding
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      cyc(1'b0, 1'b1, 32'h100, 1'b0, '0, 1'b1);
      check("drop_req", 64'(imem_req), 64'd1);
      check("drop_addr_held", 64'(imem_addr), 64'hA);
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      check("drop_addr_held2", 64'(imem_addr), 64'hA);
      addr_q.push_back(32'hA);
      cyc(1'b0, 1'b0, '0, 1'b1, 20'hDEAD0, 1'b1);
      check("drop_new_addr", 64'(imem_addr), 64'h100);
      check("drop_no_valid", 64'(instr_valid), 64'd0);
      fetch_deliver(32'h100, 20'h66666);

      // redirect coinciding with ack, odd target
      addr_q.push_back(32'h102);
      cyc(1'b0, 1'b1, 32'h41, 1'b1, 20'hBEEF0, 1'b1);
      check("rwa_req", 64'(imem_req), 64'd1);
      check("rwa_addr", 64'(imem_addr), 64'h40);
      check("rwa_no_valid", 64'(instr_valid), 64'd0);
      fetch_deliver(32'h40, 20'h77777);
`ifdef FETCH_PERF_CNT_EN
      check("count_7", 64'(fetch_count), 64'd7);
`endif

      // redirect in S_HOLD without transfer: held word is dropped
      addr_q.push_back(32'h42);
      cyc(1'b0, 1'b0, '0, 1'b1, 20'h88888, 1'b0);
      cyc(1'b0, 1'b1, 32'h200, 1'b0, '0, 1'b0);
      check("hold_redir_valid", 64'(instr_valid), 64'd0);
      check("hold_redir_addr", 64'(imem_addr), 64'h200);
`ifdef FETCH_PERF_CNT_EN
      check("count_still_7", 64'(fetch_count), 64'd7);
`endif

      // redirect together with transfer: delivered, redirect beats +STEP
      addr_q.push_back(32'h200);
      e.pc = 32'h200; e.data = 20'h99999;
      instr_q.push_back(e);
      cyc(1'b0, 1'b0, '0, 1'b1, 20'h99999, 1'b0);
      cyc(1'b0, 1'b1, 32'h300, 1'b0, '0, 1'b1);
      check("xfer_redir_addr", 64'(imem_addr), 64'h300);
      check("xfer_redir_valid", 64'(instr_valid), 64'd0);
`ifdef FETCH_PERF_CNT_EN
      check("count_8", 64'(fetch_count), 64'd8);
`endif

      // reset overrides a simultaneous ack and redirect
      addr_q.push_back(32'h300);
      cyc(1'b1, 1'b1, 32'h500, 1'b1, 20'hAAAAA, 1'b1);
      check("mrst_req", 64'(imem_req), 64'd0);
      check("mrst_addr", 64'(imem_addr), 64'h0);
      check("mrst_valid", 64'(instr_valid), 64'd0);
      check("mrst_data", 64'(instr_data), 64'h0);
      check("mrst_pc", 64'(instr_pc), 64'h0);
`ifdef FETCH_PERF_CNT_EN
      check("mrst_count", 64'(fetch_count), 64'd0);
`endif
      // stale ack in S_IDLE is ignored
      cyc(1'b0, 1'b0, '0, 1'b1, 20'hCCCCC, 1'b1);
      check("idle_ack_req", 64'(imem_req), 64'd1);
      check("idle_ack_addr", 64'(imem_addr), 64'h0);
      check("idle_ack_valid", 64'(instr_valid), 64'd0);
      fetch_deliver(32'h0, 20'hABCDE);
`ifdef FETCH_PERF_CNT_EN
      check("count_after_rst", 64'(fetch_count), 64'd1);
`endif
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);

      check("addr_q_drained", 64'(addr_q.size()), 64'd0);
      check("instr_q_drained", 64'(instr_q.size()), 64'd0);

      // wrap-around from RESET_PC = 0xFFFF_FFFE
      check("wrap_rst_addr", 64'(w_addr), 64'hFFFF_FFFE);
      check("wrap_rst_req", 64'(w_req), 64'd0);
      w_rst = 1'b0;
      @(posedge clk);
      #1;
      check("wrap_req1", 64'(w_req), 64'd1);
      check("wrap_addr1", 64'(w_addr), 64'hFFFF_FFFE);
      w_ack   = 1'b1;
      w_rdata = 20'h12345;
      @(posedge clk);
      #1;
      w_ack = 1'b0;
      check("wrap_valid", 64'(w_valid), 64'd1);
      check("wrap_instr_pc", 64'(w_pc), 64'hFFFF_FFFE);
      check("wrap_instr_data", 64'(w_data), 64'h12345);
      @(posedge clk);
      #1;
      check("wrap_req2", 64'(w_req), 64'd1);
      check("wrap_addr2", 64'(w_addr), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
